// File: rtl/soc_timer_allocator.sv
`default_nettype none
// ============================================================================
// Module   : soc_timer_allocator
// Purpose  : Round-robin allocation of shared one-shot timer channels to
//            requesters, with cancel queueing and expiry routing.
// Revision : 1.0 - initial release
// ============================================================================
module soc_timer_allocator #(
   parameter int REQ_COUNT   = 4,
   parameter int TIMER_COUNT = 4
) (
   input  logic                      clk,
   input  logic                      res,
   input  logic [REQ_COUNT-1:0]      req_valid,
   input  logic [REQ_COUNT*32-1:0]   req_period,
   output logic [REQ_COUNT-1:0]      req_ready,
   input  logic [REQ_COUNT-1:0]      req_cancel,
   output logic [REQ_COUNT-1:0]      done,
   output logic                      cfg_we,
   output logic [3:0]                cfg_index,
   output logic [31:0]               cfg_period,
   output logic                      cfg_enable,
   input  logic [TIMER_COUNT-1:0]    expire,
   output logic [TIMER_COUNT-1:0]    busy_mask
);

   logic [TIMER_COUNT-1:0] r_armed;
   logic [3:0]             r_owner  [TIMER_COUNT];
   logic [REQ_COUNT-1:0]   r_owns;
   logic [3:0]             r_own_ch [REQ_COUNT];
   logic [REQ_COUNT-1:0]   r_pend;
   logic [3:0]             r_rr_ptr;
   logic [REQ_COUNT-1:0]   r_done;
   logic                   r_cfg_we;
   logic [3:0]             r_cfg_index;
   logic [31:0]            r_cfg_period;
   logic                   r_cfg_enable;

   logic [REQ_COUNT-1:0]   w_exp_req;
   logic [REQ_COUNT-1:0]   w_cancel_raw;
   logic [REQ_COUNT-1:0]   w_cancel_set;
   logic [REQ_COUNT-1:0]   w_cancel_oh;
   logic                   w_cancel_hit;
   logic [3:0]             w_cancel_ch;
   logic                   w_any_free;
   logic [3:0]             w_free_ch;
   logic [REQ_COUNT-1:0]   w_elig;
   logic                   w_grant;
   logic [3:0]             w_win;
   logic [REQ_COUNT-1:0]   w_win_oh;
   logic [31:0]            w_win_period;
   logic                   w_win_zero;
   logic                   w_alloc;
   logic [3:0]             w_rr_next;

   // Requesters whose channel expires this cycle; expiry beats a same-cycle cancel.
   always_comb begin
      w_exp_req = '0;
      for (int t = 0; t < TIMER_COUNT; t++) begin
         for (int r = 0; r < REQ_COUNT; r++) begin
            if (expire[t] && r_armed[t] && (r_owner[t] == 4'(r)))
               w_exp_req[r] = 1'b1;
         end
      end
   end

   assign w_cancel_raw = r_pend | (req_cancel & r_owns);
   assign w_cancel_set = w_cancel_raw & ~w_exp_req;

   always_comb begin
      w_cancel_hit = 1'b0;
      w_cancel_oh  = '0;
      w_cancel_ch  = 4'd0;
      for (int r = REQ_COUNT - 1; r >= 0; r--) begin
         if (w_cancel_set[r]) begin
            w_cancel_hit = 1'b1;
            w_cancel_oh  = '0;
            w_cancel_oh[r] = 1'b1;
            w_cancel_ch  = r_own_ch[r];
         end
      end
   end

   always_comb begin
      w_any_free = 1'b0;
      w_free_ch  = 4'd0;
      for (int t = TIMER_COUNT - 1; t >= 0; t--) begin
         if (!r_armed[t]) begin
            w_any_free = 1'b1;
            w_free_ch  = 4'(t);
         end
      end
   end

   // Grants are suppressed on any cancel activity (not just a serviced one) so
   // that readiness never depends combinationally on expire.
   assign w_elig = (w_cancel_raw == '0 && w_any_free) ? (req_valid & ~r_owns) : '0;

   always_comb begin
      int k;
      k       = 0;
      w_grant = 1'b0;
      w_win   = 4'd0;
      for (int i = 0; i < REQ_COUNT; i++) begin
         k = (int'(r_rr_ptr) + i) % REQ_COUNT;
         if (!w_grant && w_elig[k]) begin
            w_grant = 1'b1;
            w_win   = 4'(k);
         end
      end
   end

   always_comb begin
      w_win_oh     = '0;
      w_win_period = 32'd0;
      for (int r = 0; r < REQ_COUNT; r++) begin
         if (w_grant && (w_win == 4'(r))) begin
            w_win_oh[r]  = 1'b1;
            w_win_period = req_period[r*32 +: 32];
         end
      end
   end

   assign w_win_zero = (w_win_period == 32'd0);
   assign w_alloc    = w_grant && !w_win_zero;
   assign w_rr_next  = 4'((int'(w_win) + 1) % REQ_COUNT);
   assign req_ready  = res ? w_win_oh : '0;

   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         r_armed      <= '0;
         r_owns       <= '0;
         r_pend       <= '0;
         r_rr_ptr     <= 4'd0;
         r_done       <= '0;
         r_cfg_we     <= 1'b0;
         r_cfg_index  <= 4'd0;
         r_cfg_period <= 32'd0;
         r_cfg_enable <= 1'b0;
         for (int t = 0; t < TIMER_COUNT; t++) r_owner[t]  <= 4'd0;
         for (int r = 0; r < REQ_COUNT; r++)   r_own_ch[r] <= 4'd0;
      end else begin
         r_done       <= w_exp_req | ((w_grant && w_win_zero) ? w_win_oh : '0);
         r_pend       <= w_cancel_set & ~w_cancel_oh;
         r_cfg_we     <= 1'b0;
         r_cfg_index  <= 4'd0;
         r_cfg_period <= 32'd0;
         r_cfg_enable <= 1'b0;
         if (w_cancel_hit) begin
            r_cfg_we    <= 1'b1;
            r_cfg_index <= w_cancel_ch;
         end else if (w_alloc) begin
            r_cfg_we     <= 1'b1;
            r_cfg_index  <= w_free_ch;
            r_cfg_period <= w_win_period;
            r_cfg_enable <= 1'b1;
         end
         if (w_grant)
            r_rr_ptr <= w_rr_next;
         for (int t = 0; t < TIMER_COUNT; t++) begin
            if (expire[t] && r_armed[t]) begin
               r_armed[t] <= 1'b0;
            end else if (w_cancel_hit && (w_cancel_ch == 4'(t))) begin
               r_armed[t] <= 1'b0;
            end else if (w_alloc && (w_free_ch == 4'(t))) begin
               r_armed[t] <= 1'b1;
               r_owner[t] <= w_win;
            end
         end
         for (int r = 0; r < REQ_COUNT; r++) begin
            if (w_exp_req[r] || w_cancel_oh[r]) begin
               r_owns[r] <= 1'b0;
            end else if (w_alloc && w_win_oh[r]) begin
               r_owns[r]   <= 1'b1;
               r_own_ch[r] <= w_free_ch;
            end
         end
      end
   end

   assign done       = r_done;
   assign cfg_we     = r_cfg_we;
   assign cfg_index  = r_cfg_index;
   assign cfg_period = r_cfg_period;
   assign cfg_enable = r_cfg_enable;
   assign busy_mask  = r_armed;

endmodule
`default_nettype wire

// File: tb/tb_soc_timer_allocator.sv
`default_nettype none
// ============================================================================
// Module   : tb_soc_timer_allocator
// Purpose  : Directed self-checking bench for soc_timer_allocator.
// Revision : 1.0 - initial release
// ============================================================================
module tb_soc_timer_allocator;

   localparam int c_req = 4;
   localparam int c_tmr = 4;

   logic               clk = 1'b0;
   logic               res;
   logic [c_req-1:0]   req_valid;
   logic [c_req*32-1:0] req_period;
   logic [c_req-1:0]   req_ready;
   logic [c_req-1:0]   req_cancel;
   logic [c_req-1:0]   done;
   logic               cfg_we;
   logic [3:0]         cfg_index;
   logic [31:0]        cfg_period;
   logic               cfg_enable;
   logic [c_tmr-1:0]   expire;
   logic [c_tmr-1:0]   busy_mask;

   int n_pass  = 0;
   int n_total = 0;

   soc_timer_allocator #(.REQ_COUNT(c_req), .TIMER_COUNT(c_tmr)) dut (
      .clk        (clk),
      .res        (res),
      .req_valid  (req_valid),
      .req_period (req_period),
      .req_ready  (req_ready),
      .req_cancel (req_cancel),
      .done       (done),
      .cfg_we     (cfg_we),
      .cfg_index  (cfg_index),
      .cfg_period (cfg_period),
      .cfg_enable (cfg_enable),
      .expire     (expire),
      .busy_mask  (busy_mask)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_cfg(input string tag, input logic we, input logic [3:0] idx,
                          input logic [31:0] per, input logic en);
      chk({tag, ".we"},     32'(cfg_we),     32'(we));
      chk({tag, ".index"},  32'(cfg_index),  32'(idx));
      chk({tag, ".period"}, cfg_period,      per);
      chk({tag, ".enable"}, 32'(cfg_enable), 32'(en));
   endtask

   initial begin
      res = 1'b0; req_valid = '0; req_period = '0; req_cancel = '0; expire = '0;
      // Reset: outputs idle and no ready even with a valid request.
      req_valid = 4'b0001; req_period[31:0] = 32'd100;
      #1;
      chk("rst.ready", 32'(req_ready), 32'h0);
      repeat (2) step();
      chk("rst.done", 32'(done), 32'h0);
      chk("rst.busy", 32'(busy_mask), 32'h0);
      chk_cfg("rst.cfg", 1'b0, 4'd0, 32'd0, 1'b0);
      req_valid = '0;
      res = 1'b1;
      step();

      // Basic allocation of channel 0 to r0.
      req_valid = 4'b0001; req_period[31:0] = 32'd100;
      #1;
      chk("basic.ready", 32'(req_ready), 32'b0001);
      step();
      req_valid = '0;
      chk_cfg("basic.cfg", 1'b1, 4'd0, 32'd100, 1'b1);
      chk("basic.busy", 32'(busy_mask), 32'b0001);
      chk("basic.done", 32'(done), 32'h0);
      step();
      chk("basic.we_once", 32'(cfg_we), 32'h0);
      expire = 4'b0001;
      step();
      expire = '0;
      chk("basic.expdone", 32'(done), 32'b0001);
      chk("basic.expbusy", 32'(busy_mask), 32'h0);
      chk("basic.expwe", 32'(cfg_we), 32'h0);
      step();
      chk("basic.done_once", 32'(done), 32'h0);

      // Zero period: immediate done, no cfg write (rr_ptr is 1 here).
      req_valid = 4'b0100; req_period = '0;
      #1;
      chk("zero.ready", 32'(req_ready), 32'b0100);
      step();
      req_valid = '0;
      chk("zero.done", 32'(done), 32'b0100);
      chk("zero.we", 32'(cfg_we), 32'h0);
      chk("zero.busy", 32'(busy_mask), 32'h0);
      step();
      chk("zero.done_once", 32'(done), 32'h0);

      // Stale expire on a free channel.
      expire = 4'b1000;
      step();
      expire = '0;
      chk("stale.done", 32'(done), 32'h0);
      chk("stale.we", 32'(cfg_we), 32'h0);
      chk("stale.busy", 32'(busy_mask), 32'h0);

      // Contention: rr_ptr=3, so order r3,r0,r1,r2 on channels 0..3.
      req_valid = 4'b1111; req_period = {32'd13, 32'd12, 32'd11, 32'd10};
      #1;
      chk("rr.ready0", 32'(req_ready), 32'b1000);
      step();
      chk_cfg("rr.cfg0", 1'b1, 4'd0, 32'd13, 1'b1);
      chk("rr.ready1", 32'(req_ready), 32'b0001);
      step();
      chk_cfg("rr.cfg1", 1'b1, 4'd1, 32'd10, 1'b1);
      chk("rr.ready2", 32'(req_ready), 32'b0010);
      step();
      chk_cfg("rr.cfg2", 1'b1, 4'd2, 32'd11, 1'b1);
      chk("rr.ready3", 32'(req_ready), 32'b0100);
      step();
      chk_cfg("rr.cfg3", 1'b1, 4'd3, 32'd12, 1'b1);
      chk("rr.busy_full", 32'(busy_mask), 32'b1111);
      chk("rr.ready_full", 32'(req_ready), 32'h0);
      step();
      chk("rr.we_idle", 32'(cfg_we), 32'h0);
      chk("rr.ready_still0", 32'(req_ready), 32'h0);
      expire = 4'b0010;
      step();
      expire = '0;
      chk("rr.exp_done", 32'(done), 32'b0001);
      chk("rr.exp_busy", 32'(busy_mask), 32'b1101);
      chk("rr.regrant_ready", 32'(req_ready), 32'b0001);
      step();
      req_valid = '0;
      chk_cfg("rr.regrant_cfg", 1'b1, 4'd1, 32'd10, 1'b1);
      chk("rr.regrant_busy", 32'(busy_mask), 32'b1111);

      // Cancel: r1 owns channel 2.
      req_cancel = 4'b0010;
      step();
      req_cancel = '0;
      chk_cfg("cancel.cfg", 1'b1, 4'd2, 32'd0, 1'b0);
      chk("cancel.busy", 32'(busy_mask), 32'b1011);
      chk("cancel.done", 32'(done), 32'h0);
      step();
      chk("cancel.done_after", 32'(done), 32'h0);
      chk("cancel.we_once", 32'(cfg_we), 32'h0);

      // Expire and cancel of r2's channel 3 in the same cycle.
      expire = 4'b1000; req_cancel = 4'b0100;
      step();
      expire = '0; req_cancel = '0;
      chk("excan.done", 32'(done), 32'b0100);
      chk("excan.we", 32'(cfg_we), 32'h0);
      chk("excan.busy", 32'(busy_mask), 32'b0011);
      step();
      chk("excan.we_late", 32'(cfg_we), 32'h0);

      // Two cancels (r0 on ch1, r3 on ch0) plus a request from r2.
      req_cancel = 4'b1001; req_valid = 4'b0100; req_period[95:64] = 32'd77;
      #1;
      chk("twocan.ready0", 32'(req_ready), 32'h0);
      step();
      req_cancel = '0;
      chk_cfg("twocan.cfg0", 1'b1, 4'd1, 32'd0, 1'b0);
      chk("twocan.ready1", 32'(req_ready), 32'h0);
      step();
      chk_cfg("twocan.cfg1", 1'b1, 4'd0, 32'd0, 1'b0);
      chk("twocan.busy1", 32'(busy_mask), 32'h0);
      chk("twocan.ready2", 32'(req_ready), 32'b0100);
      step();
      req_valid = '0;
      chk_cfg("twocan.cfg2", 1'b1, 4'd0, 32'd77, 1'b1);
      chk("twocan.busy2", 32'(busy_mask), 32'b0001);

      // Asynchronous reset while cfg_we is high.
      #2;
      res = 1'b0;
      #1;
      chk("arst.we", 32'(cfg_we), 32'h0);
      chk("arst.busy", 32'(busy_mask), 32'h0);
      chk("arst.done", 32'(done), 32'h0);
      chk("arst.cfg_en", 32'(cfg_enable), 32'h0);
      chk("arst.cfg_per", cfg_period, 32'h0);
      step();
      res = 1'b1;
      req_valid = 4'b0011; req_period[31:0] = 32'd55; req_period[63:32] = 32'd66;
      #1;
      chk("arst.ready", 32'(req_ready), 32'b0001);
      step();
      req_valid = '0;
      chk_cfg("arst.cfg", 1'b1, 4'd0, 32'd55, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/soc_timer_allocator.md
# soc_timer_allocator

Shares a pool of hardware timer channels among several requesters so that no requester needs a fixed channel. Requesters ask for a one-shot delay of a given period. The block grants a free channel round-robin, programs it through a single configuration port, and reports expiry back to the owning requester. It sits between requester logic (DMA sequencers, software-assist engines) and the timer peripheral's channel configuration and expiry signals.

## Interface
Parameters:
- REQ_COUNT, 4, number of requesters (1..16)
- TIMER_COUNT, 4, number of timer channels managed (1..16)

Ports:
- clk  input  1  system clock; all state on rising edge
- res  input  1  reset, asynchronous, active-low
- req_valid  input  REQ_COUNT  requester r asks for a timer
- req_period  input  REQ_COUNT×32  requested period, sampled on handshake
- req_ready  output  REQ_COUNT  combinational accept; transfer when valid&ready
- req_cancel  input  REQ_COUNT  one-cycle pulse, abort r's running timer
- done  output  REQ_COUNT  one-cycle pulse, r's delay elapsed
- cfg_we  output  1  one-cycle channel configuration strobe
- cfg_index  output  4  channel being configured
- cfg_period  output  32  period value for the channel
- cfg_enable  output  1  1 = start one-shot with cfg_period; 0 = stop channel
- expire  input  TIMER_COUNT  one-cycle pulse per channel when its period is reached
- busy_mask  output  TIMER_COUNT  channel currently owned

## Operation
- Per-channel state is FREE or ARMED, plus a 4-bit owner. Per-requester state is an owns bit plus a 4-bit channel index.
- Eligible requester: req_valid=1, owns=0, and no cancel being serviced this cycle.
- Allocation requires at least one FREE channel.
  - The winner is the first eligible requester at or after rr_ptr, searching with wrap.
  - Only the winner sees req_ready=1. At most one grant per cycle.
  - The chosen channel is the lowest-index FREE one.
- On grant (req_period≠0):
  - Channel becomes ARMED with owner = winner, and the winner's owns bit is set.
  - Next cycle: cfg_we=1, cfg_index=channel, cfg_period=sampled period, cfg_enable=1.
  - rr_ptr ← winner+1 mod REQ_COUNT.
- On grant with req_period=0: no channel is allocated and no cfg write occurs. done[r] pulses the next cycle. rr_ptr still advances.
- expire[t] with t ARMED: done[owner] pulses the next cycle. Channel becomes FREE and owns[owner] clears at that edge, so the channel is allocatable from the next cycle. No cfg write is needed, because channels run one-shot.
- expire[t] with t FREE (stale or spurious): ignored.
- req_cancel[r] with owns[r]=1:
  - Next cycle: cfg_we=1, cfg_index=owned channel, cfg_enable=0, cfg_period=0.
  - Channel is freed and owns[r] clears. No done pulse.
- req_cancel[r] with owns[r]=0: ignored.
- cfg port arbitration, highest first:
  - Cancels, lowest requester index first, one per cycle. Other cancels stay pending in a per-requester pending bit until serviced.
  - Allocation. No grant in any cycle where a cancel is serviced.
- Expire and cancel for the same channel in the same cycle: expire wins. done pulses, and the cancel is dropped and its pending bit cleared.
- Several expires in one cycle: all are processed in parallel, with multiple done bits possible.
- busy_mask[t] = 1 iff channel t is ARMED (registered).

## Timing
- Reset (res=0, asynchronous):
  - All channels FREE, owns=0, pending cancels=0, rr_ptr=0.
  - done=0, cfg_we=0, cfg_index=0, cfg_period=0, cfg_enable=0, busy_mask=0.
  - req_ready=0 while in reset.
- Reset deassertion mid-operation: channels are not stopped by this block. Stale expires after reset are ignored.
- Handshake to cfg_we: 1 cycle.
- expire to done: 1 cycle.
- cancel to cfg_we: 1 cycle when not queued behind other cancels, otherwise +1 cycle per earlier cancel.
- A channel released at edge E can be granted in the cycle following E.
- The owner may re-request in the cycle after done; it is eligible in that cycle.
- req_ready depends only on registered state plus req_valid and cancel inputs. There is no combinational path from expire to req_ready.
- All outputs except req_ready are registered.
- cfg_we is high for exactly one cycle per operation; back-to-back cycles are allowed.

## Test plan
- Basic allocation: req_valid[0]=1 with period=100 → req_ready[0] in the same cycle. Next cycle: cfg_we=1, cfg_index=0, cfg_period=100, cfg_enable=1, busy_mask=0001. Then expire[0] → done[0] the next cycle and busy_mask=0000.
- Round-robin under contention: all 4 requesters valid, 2 channels.
  - Grants go to r0 then r1; the pool is then full and req_ready stays 0.
  - expire[0] frees the channel → r2 is granted on channel 0.
  - expire[1] frees the channel → r3 is granted on channel 1.
- Cancel: r1 owns channel 2, then req_cancel[1] → cfg_we=1, cfg_index=2, cfg_enable=0 the next cycle. busy_mask[2]=0 and done[1] never pulses.
- Simultaneous events:
  - expire[2] and req_cancel for its owner in the same cycle → done pulses and no cfg write occurs.
  - Two cancels plus a valid request in the same cycle → cancels are serviced in consecutive cycles (lower index first), and the grant follows in the third cycle.
- Edge values:
  - period=0 → no cfg_we, and done pulses 1 cycle after the handshake.
  - Stale expire[3] on a FREE channel → no output change.
- Async reset: assert res=0 mid-cfg_we → all outputs are 0 immediately, before the next edge. After release, the first request gets channel 0 and rr_ptr restarts at r0.
